// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO wave readout path.
package nco_pkg;

    typedef enum logic [1:0] {
        SHAPE_SINE   = 2'd0,
        SHAPE_SAW    = 2'd1,
        SHAPE_SQUARE = 2'd2,
        SHAPE_TRI    = 2'd3
    } shape_e;

    localparam int                 PHASE_W    = 11;
    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;
    localparam logic [10:0]        PW_RESET   = 11'd1024;

endpackage

// File: rtl/nco_wave_rd_if.sv
// Slot phase stream, shape-register write port and sample output of nco_wave_rd.
// pw_data exists only when NCO_PWM_EN is defined.
interface nco_wave_rd_if #(
    parameter int V_WIDTH   = 3,
    parameter int O_WIDTH   = 2,
    parameter int OUT_WIDTH = 16
);
    logic [10:0]                 phase_in;
    logic [V_WIDTH-1:0]          vx;
    logic [O_WIDTH-1:0]          ox;
    logic                        slot_valid;
    logic                        shape_we;
    logic [V_WIDTH-1:0]          shape_vx;
    logic [O_WIDTH-1:0]          shape_ox;
    logic [1:0]                  shape_data;
`ifdef NCO_PWM_EN
    logic [10:0]                 pw_data;
`endif
    logic signed [OUT_WIDTH-1:0] wave_out;
    logic [V_WIDTH-1:0]          wave_vx;
    logic [O_WIDTH-1:0]          wave_ox;
    logic                        wave_valid;
    logic                        wrap_out;

    modport master (
`ifdef NCO_PWM_EN
        output pw_data,
`endif
        output phase_in, vx, ox, slot_valid,
        output shape_we, shape_vx, shape_ox, shape_data,
        input  wave_out, wave_vx, wave_ox, wave_valid, wrap_out
    );

    modport slave (
`ifdef NCO_PWM_EN
        input  pw_data,
`endif
        input  phase_in, vx, ox, slot_valid,
        input  shape_we, shape_vx, shape_ox, shape_data,
        output wave_out, wave_vx, wave_ox, wave_valid, wrap_out
    );
endinterface

// File: rtl/nco_sine_qrom.sv
// 512x15 quarter-wave sine ROM, registered address, data valid one cycle later.
// Contents are round(32767*sin(pi*(i+0.5)/1024)), built at elaboration in Q60 fixed point.
module nco_sine_qrom (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  addr,
    output logic [14:0] data
);
    localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

    function automatic logic [14:0] sine_entry(input int unsigned idx);
        logic signed [127:0] x, x2, term, sum, scaled;
        x    = (PI_Q60 * $signed(128'(2 * idx + 1))) >>> 11;
        x2   = (x * x) >>> 60;
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -(((term * x2) >>> 60) / $signed(128'((2 * k) * (2 * k + 1))));
            sum  = sum + term;
        end
        scaled = (sum * 128'sd32767 + (128'sd1 <<< 59)) >>> 60;
        return scaled[14:0];
    endfunction

    logic [14:0] mem [512];
    logic [8:0]  addr_q, addr_d;

    for (genvar g = 0; g < 512; g++) begin : g_rom
        assign mem[g] = sine_entry(g);
    end

    always_comb addr_d = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
    end

    assign data = mem[addr_q];
endmodule

// File: rtl/nco_wave_rd.sv
// Per-slot phase-to-sample converter: 3-stage pipeline, per-slot shape/prev-phase regfile, wrap flag.
// Optional NCO_PWM_EN adds a per-slot pulse-width register for SQUARE.
module nco_wave_rd
    import nco_pkg::*;
#(
    parameter int VOICES    = 8,
    parameter int V_OSC     = 4,
    parameter int V_WIDTH   = 3,
    parameter int O_WIDTH   = 2,
    parameter int OUT_WIDTH = 16
) (
    input logic          sCLK_XVXOSC,
    input logic          reset,
    nco_wave_rd_if.slave bus
);
    localparam int SLOTS = VOICES * V_OSC;

    shape_e               shape_q [SLOTS], shape_d [SLOTS];
    logic [PHASE_W-1:0]   prev_q  [SLOTS], prev_d  [SLOTS];
`ifdef NCO_PWM_EN
    logic [PHASE_W-1:0]   pw_q    [SLOTS], pw_d    [SLOTS];
    logic [PHASE_W-1:0]   s1_pw_q, s1_pw_d;
`endif

    logic                 s1_valid_q, s1_valid_d;
    logic [PHASE_W-1:0]   s1_p_q, s1_p_d, s1_prev_q, s1_prev_d;
    shape_e               s1_shape_q, s1_shape_d;
    logic [V_WIDTH-1:0]   s1_vx_q, s1_vx_d;
    logic [O_WIDTH-1:0]   s1_ox_q, s1_ox_d;

    logic                 s2_valid_q, s2_valid_d, s2_wrap_q, s2_wrap_d, s2_neg_q, s2_neg_d;
    shape_e               s2_shape_q, s2_shape_d;
    logic signed [15:0]   s2_alt_q, s2_alt_d;
    logic [V_WIDTH-1:0]   s2_vx_q, s2_vx_d;
    logic [O_WIDTH-1:0]   s2_ox_q, s2_ox_d;

    logic signed [OUT_WIDTH-1:0] wave_q, wave_d;
    logic [V_WIDTH-1:0]   wvx_q, wvx_d;
    logic [O_WIDTH-1:0]   wox_q, wox_d;
    logic                 wvalid_q, wvalid_d, wrap_q, wrap_d;

    logic [8:0]           rom_addr;
    logic [14:0]          rom_data;
    logic [9:0]           tri_t;
    logic                 sq_high;
    logic signed [15:0]   rom_s, sine_s;

    nco_sine_qrom u_qrom (
        .clk  (sCLK_XVXOSC),
        .rst  (reset),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_comb begin
        shape_d = shape_q;
        prev_d  = prev_q;
`ifdef NCO_PWM_EN
        pw_d    = pw_q;
`endif
        // Stage-1 reads below use the _q copies, so a same-cycle write only affects later samples.
        if (bus.slot_valid) prev_d[{bus.vx, bus.ox}] = bus.phase_in;
        if (bus.shape_we) begin
            shape_d[{bus.shape_vx, bus.shape_ox}] = shape_e'(bus.shape_data);
`ifdef NCO_PWM_EN
            pw_d[{bus.shape_vx, bus.shape_ox}]    = bus.pw_data;
`endif
        end

        s1_valid_d = bus.slot_valid;
        s1_p_d     = bus.phase_in;
        s1_vx_d    = bus.vx;
        s1_ox_d    = bus.ox;
        s1_shape_d = shape_q[{bus.vx, bus.ox}];
        s1_prev_d  = prev_q[{bus.vx, bus.ox}];
`ifdef NCO_PWM_EN
        s1_pw_d    = pw_q[{bus.vx, bus.ox}];
        sq_high    = s1_p_q < s1_pw_q;
`else
        sq_high    = ~s1_p_q[10];
`endif

        s2_valid_d = s1_valid_q;
        s2_wrap_d  = s1_p_q < s1_prev_q;
        s2_neg_d   = s1_p_q[10];
        s2_shape_d = s1_shape_q;
        s2_vx_d    = s1_vx_q;
        s2_ox_d    = s1_ox_q;
        rom_addr   = s1_p_q[9] ? ~s1_p_q[8:0] : s1_p_q[8:0];
        tri_t      = s1_p_q[10] ? ~s1_p_q[9:0] : s1_p_q[9:0];
        case (s1_shape_q)
            SHAPE_SAW:    s2_alt_d = {s1_p_q, 5'b0} ^ 16'h8000;
            SHAPE_SQUARE: s2_alt_d = sq_high ? SAMPLE_MAX : SAMPLE_MIN;
            SHAPE_TRI:    s2_alt_d = {tri_t, 6'b0} ^ 16'h8000;
            default:      s2_alt_d = '0;
        endcase

        rom_s    = {1'b0, rom_data};
        sine_s   = s2_neg_q ? -rom_s : rom_s;
        wave_d   = wave_q;
        wvx_d    = wvx_q;
        wox_d    = wox_q;
        wvalid_d = s2_valid_q;
        wrap_d   = s2_valid_q & s2_wrap_q;
        if (s2_valid_q) begin
            wave_d = (s2_shape_q == SHAPE_SINE) ? sine_s : s2_alt_q;
            wvx_d  = s2_vx_q;
            wox_d  = s2_ox_q;
        end
    end

    always_ff @(posedge sCLK_XVXOSC or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                shape_q[i] <= SHAPE_SINE;
                prev_q[i]  <= '0;
`ifdef NCO_PWM_EN
                pw_q[i]    <= PW_RESET;
`endif
            end
`ifdef NCO_PWM_EN
            s1_pw_q    <= '0;
`endif
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_prev_q  <= '0;
            s1_shape_q <= SHAPE_SINE;
            s1_vx_q    <= '0;
            s1_ox_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_wrap_q  <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_shape_q <= SHAPE_SINE;
            s2_alt_q   <= '0;
            s2_vx_q    <= '0;
            s2_ox_q    <= '0;
            wave_q     <= '0;
            wvx_q      <= '0;
            wox_q      <= '0;
            wvalid_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            shape_q    <= shape_d;
            prev_q     <= prev_d;
`ifdef NCO_PWM_EN
            pw_q       <= pw_d;
            s1_pw_q    <= s1_pw_d;
`endif
            s1_valid_q <= s1_valid_d;
            s1_p_q     <= s1_p_d;
            s1_prev_q  <= s1_prev_d;
            s1_shape_q <= s1_shape_d;
            s1_vx_q    <= s1_vx_d;
            s1_ox_q    <= s1_ox_d;
            s2_valid_q <= s2_valid_d;
            s2_wrap_q  <= s2_wrap_d;
            s2_neg_q   <= s2_neg_d;
            s2_shape_q <= s2_shape_d;
            s2_alt_q   <= s2_alt_d;
            s2_vx_q    <= s2_vx_d;
            s2_ox_q    <= s2_ox_d;
            wave_q     <= wave_d;
            wvx_q      <= wvx_d;
            wox_q      <= wox_d;
            wvalid_q   <= wvalid_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus.wave_out   = wave_q;
    assign bus.wave_vx    = wvx_q;
    assign bus.wave_ox    = wox_q;
    assign bus.wave_valid = wvalid_q;
    assign bus.wrap_out   = wrap_q;
endmodule

// File: tb/tb_nco_wave_rd.sv
// Randomized bench for nco_wave_rd against a per-slot behavioural model with a 3-cycle expectation queue.
module tb_nco_wave_rd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nco_wave_rd_if bus();

    nco_wave_rd dut (
        .sCLK_XVXOSC (clk),
        .reset       (rst),
        .bus         (bus)
    );

    typedef struct {
        bit v;
        int out;
        int vx;
        int ox;
        bit wrap;
    } exp_t;

    exp_t exp_q[$];
    int   rom_m   [512];
    int   shape_m [32];
    int   prev_m  [32];
    int   pw_m    [32];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ph1     [32];

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            shape_m[i] = 0;
            prev_m[i]  = 0;
            pw_m[i]    = 1024;
        end
    endfunction

    function automatic int model_sample(input int sh, input int p, input int pw);
        int q, r, v, t;
        case (sh)
            0: begin
                q = p / 512;
                r = p % 512;
                v = rom_m[(q % 2) ? 511 - r : r];
                return (q >= 2) ? -v : v;
            end
            1: return p * 32 - 32768;
            2: return (p < pw) ? 32767 : -32768;
            default: begin
                t = (p < 1024) ? p : 2047 - p;
                return t * 64 - 32768;
            end
        endcase
    endfunction

    task automatic cyc(input bit v, input int vx, input int ox, input int p,
                       input bit we = 1'b0, input int wvx = 0, input int wox = 0,
                       input int wsh = 0, input int wpw = 1024);
        exp_t e;
        int   s;
        bus.slot_valid = v;
        bus.vx         = 3'(vx);
        bus.ox         = 2'(ox);
        bus.phase_in   = 11'(p);
        bus.shape_we   = we;
        bus.shape_vx   = 3'(wvx);
        bus.shape_ox   = 2'(wox);
        bus.shape_data = 2'(wsh);
`ifdef NCO_PWM_EN
        bus.pw_data    = 11'(wpw);
`endif
        e.v = v; e.vx = vx; e.ox = ox; e.out = 0; e.wrap = 1'b0;
        if (v) begin
            s         = vx * 4 + ox;
            e.out     = model_sample(shape_m[s], p, pw_m[s]);
            e.wrap    = p < prev_m[s];
            prev_m[s] = p;
        end
        if (we) begin
            shape_m[wvx * 4 + wox] = wsh;
`ifdef NCO_PWM_EN
            pw_m[wvx * 4 + wox]    = wpw;
`endif
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            check("wave_valid", int'(bus.wave_valid), int'(e.v));
            if (e.v) begin
                check("wave_out", int'(bus.wave_out), e.out);
                check("wave_vx", int'(bus.wave_vx), e.vx);
                check("wave_ox", int'(bus.wave_ox), e.ox);
                check("wrap_out", int'(bus.wrap_out), int'(e.wrap));
            end else begin
                check("wrap_idle", int'(bus.wrap_out), 0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", int'(bus.wave_valid), 0);
        check("rst_out", int'(bus.wave_out), 0);
        check("rst_wrap", int'(bus.wrap_out), 0);
        bus.slot_valid = 1'b0;
        bus.shape_we   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++)
            rom_m[i] = $rtoi($floor(32767.0 * $sin(3.14159265358979323846 * (real'(i) + 0.5) / 1024.0) + 0.5));
        bus.slot_valid = 1'b0;
        bus.shape_we   = 1'b0;
        bus.vx = '0; bus.ox = '0; bus.phase_in = '0;
        bus.shape_vx = '0; bus.shape_ox = '0; bus.shape_data = '0;
`ifdef NCO_PWM_EN
        bus.pw_data = '0;
`endif
        do_reset();

        // First sample after reset: SINE, rom[0], no wrap
        cyc(1'b1, 0, 0, 0);
        idle(3);

        // SINE quadrants on one slot
        cyc(1'b1, 3, 2, 512);
        cyc(1'b1, 3, 2, 1536);
        cyc(1'b1, 3, 2, 1024);
        idle(3);

        // SAW then TRI on slot (2,1)
        cyc(1'b0, 0, 0, 0, 1'b1, 2, 1, 1);
        cyc(1'b1, 2, 1, 0);
        cyc(1'b1, 2, 1, 1023);
        cyc(1'b1, 2, 1, 2047);
        cyc(1'b0, 0, 0, 0, 1'b1, 2, 1, 3);
        cyc(1'b1, 2, 1, 1023);
        idle(3);

        // Random shapes, then two back-to-back passes over all 32 slots, second pass lower
        for (int s = 0; s < 32; s++)
            cyc(1'b0, 0, 0, 0, 1'b1, s / 4, s % 4, int'($urandom_range(0, 3)), int'($urandom_range(0, 2047)));
        for (int s = 0; s < 32; s++) begin
            ph1[s] = int'($urandom_range(1, 2047));
            cyc(1'b1, s / 4, s % 4, ph1[s]);
        end
        for (int s = 0; s < 32; s++)
            cyc(1'b1, s / 4, s % 4, int'($urandom_range(0, ph1[s] - 1)));
        idle(3);

        // Same-cycle write to slot 5 (vx=1, ox=1): read-before-write
        cyc(1'b0, 0, 0, 0, 1'b1, 1, 1, 0);
        cyc(1'b1, 1, 1, 700, 1'b1, 1, 1, 2, 1024);
        cyc(1'b1, 1, 1, 300);
        cyc(1'b1, 1, 1, 1500);
        idle(3);

`ifdef NCO_PWM_EN
        cyc(1'b0, 0, 0, 0, 1'b1, 1, 1, 2, 256);
        cyc(1'b1, 1, 1, 255);
        cyc(1'b1, 1, 1, 256);
        cyc(1'b0, 0, 0, 0, 1'b1, 1, 1, 2, 0);
        cyc(1'b1, 1, 1, 0);
        idle(3);
`endif

        // Random traffic with interleaved shape/pw writes
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2047)), $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2047)));

        // Reset mid-stream: slot (2,1) with high phase and non-sine shape in flight
        cyc(1'b0, 0, 0, 0, 1'b1, 2, 1, 1);
        cyc(1'b1, 2, 1, 2047);
        cyc(1'b1, 0, 1, 1800);
        cyc(1'b1, 1, 0, 1900);
        do_reset();
        idle(5);
        cyc(1'b1, 2, 1, 100);
        cyc(1'b1, 0, 1, 5);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
